// File: rtl/gmii_frame_gen.sv
// GMII frame stimulus source: preamble, SFD, patterned payload and IFG, repeated per start
// request, launched only while the PCS synchronizer reports code sync.
module gmii_frame_gen #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned PAYLOAD_LEN  = 16,
  parameter int unsigned IFG_LEN      = 12,
  parameter int unsigned NUM_FRAMES   = 4,
  parameter int unsigned DATA_MODE    = 0,
  parameter int unsigned ERR_EN       = 0,
  parameter int unsigned ERR_FRAME    = 1,
  parameter int unsigned ERR_BYTE     = 3
) (
  input  logic       Clk,
  input  logic       mr_main_reset,
  input  logic       start,
  input  logic       stop,
  input  logic       code_sync_status,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_PREAMBLE, S_SFD, S_PAYLOAD, S_ABORT, S_IFG, S_DONE
  } state_e;

  localparam logic [7:0] PRE_LAST    = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] PAY_LAST    = 8'(PAYLOAD_LEN - 1);
  localparam logic [7:0] IFG_LAST    = 8'(IFG_LEN - 1);
  localparam logic [7:0] NUM_LAST    = 8'(NUM_FRAMES - 1);
  localparam logic [7:0] ERR_FRAME_B = 8'(ERR_FRAME);
  localparam logic [7:0] ERR_BYTE_B  = 8'(ERR_BYTE);
  // Out-of-range error coordinates disable injection instead of aliasing after truncation.
  localparam bit ERR_ACTIVE = (ERR_EN != 0) && (ERR_FRAME < NUM_FRAMES) &&
                              (ERR_BYTE < PAYLOAD_LEN);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       stop_seen_q, stop_seen_d;
  logic       aborted_q, aborted_d;
  logic [7:0] txd_q, txd_d;
  logic       tx_en_q, tx_en_d;
  logic       tx_er_q, tx_er_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       in_frame;

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign in_frame = state_q inside {S_PREAMBLE, S_SFD, S_PAYLOAD};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    frame_cnt_d = frame_cnt_q;
    stop_seen_d = stop_seen_q | (stop && (state_q != S_IDLE));
    aborted_d   = aborted_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;

    if (in_frame && !code_sync_status) begin
      state_d   = S_ABORT;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = S_WAIT_SYNC;
            frame_cnt_d = 8'h00;
          end
        end
        S_WAIT_SYNC: begin
          if (stop_seen_q || stop) begin
            state_d = S_DONE;
          end else if (code_sync_status) begin
            state_d = S_PREAMBLE;
            cnt_d   = 8'h00;
          end
        end
        S_PREAMBLE: begin
          if (cnt_q == PRE_LAST) state_d = S_SFD;
          else                   cnt_d   = cnt_q + 8'd1;
        end
        S_SFD: begin
          state_d = S_PAYLOAD;
          cnt_d   = 8'h00;
        end
        S_PAYLOAD: begin
          if (cnt_q == PAY_LAST) begin
            state_d = S_IFG;
            cnt_d   = 8'h00;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_ABORT: begin
          state_d = S_IFG;
          cnt_d   = 8'h00;
        end
        S_IFG: begin
          if (cnt_q == IFG_LAST) begin
            if (!aborted_q) frame_cnt_d = frame_cnt_q + 8'd1;
            aborted_d = 1'b0;
            // With sync held the next preamble follows the IFG directly, so WAIT_SYNC
            // only adds a cycle when the link is actually down.
            if ((!aborted_q && (frame_cnt_q == NUM_LAST)) || stop_seen_q || stop) begin
              state_d = S_DONE;
            end else if (code_sync_status) begin
              state_d = S_PREAMBLE;
              cnt_d   = 8'h00;
            end else begin
              state_d = S_WAIT_SYNC;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the state being entered, so they register on that edge.
    unique case (state_d)
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = 8'h55;
      end
      S_SFD: begin
        tx_en_d = 1'b1;
        txd_d   = 8'hD5;
        lfsr_d  = 8'h01;
      end
      S_PAYLOAD: begin
        tx_en_d = 1'b1;
        txd_d   = (DATA_MODE == 1) ? lfsr_q : (frame_cnt_q + cnt_d);
        lfsr_d  = lfsr_next(lfsr_q);
        tx_er_d = ERR_ACTIVE && (frame_cnt_q == ERR_FRAME_B) && (cnt_d == ERR_BYTE_B);
      end
      S_ABORT: begin
        tx_en_d = 1'b1;
        tx_er_d = 1'b1;
      end
      default: ;
    endcase

    if (state_d == S_IDLE) stop_seen_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!mr_main_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'h00;
      lfsr_q      <= 8'h01;
      frame_cnt_q <= 8'h00;
      stop_seen_q <= 1'b0;
      aborted_q   <= 1'b0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      stop_seen_q <= stop_seen_d;
      aborted_q   <= aborted_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign TXD       = txd_q;
  assign TX_EN     = tx_en_q;
  assign TX_ER     = tx_er_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Directed scoreboard bench for gmii_frame_gen: three parameterisations share sync/stop/reset,
// expected frame beats are queued at start and compared as the selected DUT transmits.
module tb_gmii_frame_gen;

  localparam int PRE = 7;

  typedef struct packed {
    logic [7:0] txd;
    logic       er;
  } beat_t;

  logic clk;
  logic rst_n, start_a, start_e, start_l, stop, sync;
  logic [7:0] txd_a, txd_e, txd_l, fc_a, fc_e, fc_l;
  logic en_a, en_e, en_l, er_a, er_e, er_l;
  logic busy_a, busy_e, busy_l, done_a, done_e, done_l;

  int sel;
  logic [7:0] o_txd, o_fc;
  logic o_en, o_er, o_busy, o_done;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;

  gmii_frame_gen u_dut_a (
    .Clk(clk), .mr_main_reset(rst_n), .start(start_a), .stop(stop),
    .code_sync_status(sync), .TXD(txd_a), .TX_EN(en_a), .TX_ER(er_a),
    .busy(busy_a), .done(done_a), .frame_cnt(fc_a)
  );

  gmii_frame_gen #(.ERR_EN(1), .ERR_FRAME(1), .ERR_BYTE(3)) u_dut_e (
    .Clk(clk), .mr_main_reset(rst_n), .start(start_e), .stop(stop),
    .code_sync_status(sync), .TXD(txd_e), .TX_EN(en_e), .TX_ER(er_e),
    .busy(busy_e), .done(done_e), .frame_cnt(fc_e)
  );

  gmii_frame_gen #(.DATA_MODE(1), .PAYLOAD_LEN(4)) u_dut_l (
    .Clk(clk), .mr_main_reset(rst_n), .start(start_l), .stop(stop),
    .code_sync_status(sync), .TXD(txd_l), .TX_EN(en_l), .TX_ER(er_l),
    .busy(busy_l), .done(done_l), .frame_cnt(fc_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    o_txd = txd_a; o_en = en_a; o_er = er_a; o_busy = busy_a; o_done = done_a; o_fc = fc_a;
    if (sel == 1) begin
      o_txd = txd_e; o_en = en_e; o_er = er_e; o_busy = busy_e; o_done = done_e; o_fc = fc_e;
    end else if (sel == 2) begin
      o_txd = txd_l; o_en = en_l; o_er = er_l; o_busy = busy_l; o_done = done_l; o_fc = fc_l;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Queue one frame; cut >= 0 truncates after payload byte cut and appends the abort beat.
  task automatic push_frame(input int f, input int plen, input int mode,
                            input int err_f, input int err_k, input int cut);
    logic [7:0] lfsr_tab [4];
    logic [7:0] b;
    lfsr_tab = '{8'h01, 8'h02, 8'h04, 8'h08};
    for (int i = 0; i < PRE; i++) exp_q.push_back('{txd: 8'h55, er: 1'b0});
    exp_q.push_back('{txd: 8'hD5, er: 1'b0});
    for (int k = 0; k < plen; k++) begin
      if (cut >= 0 && k > cut) break;
      b = (mode == 1) ? lfsr_tab[k] : 8'(f + k);
      exp_q.push_back('{txd: b, er: (f == err_f && k == err_k)});
    end
    if (cut >= 0) exp_q.push_back('{txd: 8'h00, er: 1'b1});
  endtask

  task automatic drain(input string tag, input int n, input int f, input int drop_at);
    int w;
    beat_t e;
    w = 0;
    while (o_en !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    check({tag, "_start"}, {31'd0, o_en}, 32'd1);
    if (o_en !== 1'b1) begin
      for (int i = 0; i < n && exp_q.size() > 0; i++) void'(exp_q.pop_front());
      return;
    end
    check({tag, "_busy_fc"}, {o_busy, o_fc}, {1'b1, 8'(f)});
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 32'd0, 32'd1);
        return;
      end
      e = exp_q.pop_front();
      check($sformatf("%s_b%0d", tag, i), {o_en, o_er, o_txd}, {1'b1, e.er, e.txd});
      if (i == drop_at) sync = 1'b0;
      step();
    end
    check({tag, "_end"}, {o_en, o_er}, 2'b00);
  endtask

  task automatic idle_gap(input string tag, input int exp_len);
    int n;
    logic er_seen;
    n = 0;
    er_seen = 1'b0;
    while (o_en !== 1'b1 && n < 100) begin
      er_seen = er_seen | o_er;
      n++;
      step();
    end
    check({tag, "_gap"}, n, exp_len);
    check({tag, "_gap_er"}, {31'd0, er_seen}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [7:0] exp_fc);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_done_lat"}, n, exp_lat);
    check({tag, "_done_fc"}, {o_done, o_busy, o_fc}, {1'b1, 1'b1, exp_fc});
    step();
    check({tag, "_after_done"}, {o_done, o_busy, o_fc}, {1'b0, 1'b0, exp_fc});
  endtask

  initial begin
    int en_seen;
    sel = 0;
    rst_n = 1'b0;
    start_a = 1'b1; start_e = 1'b1; start_l = 1'b1;
    stop = 1'b0;
    sync = 1'b1;

    // Reset with start held: every instance stays quiet.
    repeat (2) begin
      step();
      for (int s = 0; s < 3; s++) begin
        sel = s;
        #1;
        check($sformatf("reset_dut%0d", s), {o_txd, o_en, o_er, o_busy, o_done, o_fc}, 32'd0);
      end
    end
    sel = 0;
    rst_n = 1'b1;
    start_a = 1'b0; start_e = 1'b0; start_l = 1'b0;
    step();
    check("idle_after_reset", {o_en, o_busy, o_done}, 3'b000);

    // Basic run: four incrementing frames, 12-cycle gaps, done after the last IFG.
    for (int f = 0; f < 4; f++) push_frame(f, 16, 0, -1, -1, -1);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int f = 0; f < 4; f++) begin
      drain($sformatf("basic_f%0d", f), PRE + 1 + 16, f, -1);
      if (f < 3) idle_gap($sformatf("basic_f%0d", f), 12);
      else       wait_done("basic", 12, 8'd4);
    end

    // Sync gating: nothing transmitted until one edge after sync rises; stop ends after frame 0.
    sync = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    en_seen = 0;
    repeat (10) begin
      if (o_en !== 1'b0) en_seen++;
      step();
    end
    check("gate_no_tx", en_seen, 0);
    check("gate_busy", {31'd0, o_busy}, 32'd1);
    sync = 1'b1;
    step();
    check("gate_first", {o_en, o_txd}, {1'b1, 8'h55});
    stop = 1'b1;
    push_frame(0, 16, 0, -1, -1, -1);
    drain("gate_f0", PRE + 1 + 16, 0, -1);
    wait_done("gate", 12, 8'd1);
    stop = 1'b0;

    // Error injection on frame 1, payload byte 3.
    sel = 1;
    for (int f = 0; f < 4; f++) push_frame(f, 16, 0, 1, 3, -1);
    start_e = 1'b1;
    step();
    start_e = 1'b0;
    for (int f = 0; f < 4; f++) begin
      drain($sformatf("err_f%0d", f), PRE + 1 + 16, f, -1);
      if (f < 3) idle_gap($sformatf("err_f%0d", f), 12);
      else       wait_done("err", 12, 8'd4);
    end

    // LFSR payload, restarted from 0x01 in every frame.
    sel = 2;
    for (int f = 0; f < 4; f++) push_frame(f, 4, 1, -1, -1, -1);
    start_l = 1'b1;
    step();
    start_l = 1'b0;
    for (int f = 0; f < 4; f++) begin
      drain($sformatf("lfsr_f%0d", f), PRE + 1 + 4, f, -1);
      if (f < 3) idle_gap($sformatf("lfsr_f%0d", f), 12);
      else       wait_done("lfsr", 12, 8'd4);
    end

    // Sync loss at payload byte 5 of frame 0, then a resend cut short by stop.
    sel = 0;
    push_frame(0, 16, 0, -1, -1, 5);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    drain("loss_f0", PRE + 1 + 6 + 1, 0, PRE + 1 + 5);
    check("loss_fc", {o_busy, o_fc}, {1'b1, 8'd0});
    en_seen = 0;
    repeat (20) begin
      if (o_en !== 1'b0) en_seen++;
      step();
    end
    check("loss_hold", en_seen, 0);
    check("loss_wait_fc", {o_busy, o_fc}, {1'b1, 8'd0});
    sync = 1'b1;
    step();
    check("loss_resend_first", {o_en, o_txd}, {1'b1, 8'h55});
    stop = 1'b1;
    push_frame(0, 16, 0, -1, -1, -1);
    drain("loss_resend", PRE + 1 + 16, 0, -1);
    wait_done("loss", 12, 8'd1);
    stop = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
